// File: rtl/dma_job_sched.sv
// dma_job_sched: round-robin arbiter + shared descriptor FIFO feeding dma_fsm one job at a time.
// Latency: accept in cycle t into an idle, empty block -> dma_go_o in t+2; cpl handshake c -> next go at c+2.
// Backpressure: req_ready_o all low while the queue is full; a stalled completion stops issue, queue keeps filling.
// Build option: define DMA_JOB_SCHED_PRIO_EN to make requester 0 strict priority over a round-robin of the rest.

package dma_job_sched_pkg;

  typedef enum logic {
    ERR_SRC_RD = 1'b0,
    ERR_SRC_WR = 1'b1
  } e_dma_err_src_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic done;
    logic error;
  } s_dma_status_t;

  typedef struct packed {
    logic           valid;
    e_dma_err_src_t src;
    logic [31:0]    addr;
  } s_dma_error_t;

endpackage

// dma_job_fifo: generic synchronous FIFO, storage is a flop array.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes are dropped while full, pops ignored while empty; no bypass.
module dma_job_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;

  // Next pointers, occupancy and storage; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// dma_job_sched: arbitrates N_REQ requesters into one queue and runs each job through dma_fsm.
// Latency: accept t -> go t+2 when idle and empty; completion handshake c -> next go c+2.
// Backpressure: ready withheld when queue full (even on a same-cycle pop); cpl_ready_i low holds the job in CPL.
module dma_job_sched
  import dma_job_sched_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int QUEUE_DEPTH = 8,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  s_dma_desc_t [N_REQ-1:0] req_desc_i,
  output logic                    cpl_valid_o,
  input  logic                    cpl_ready_i,
  output logic [ID_W-1:0]         cpl_id_o,
  output s_dma_error_t            cpl_error_o,
  output logic                    dma_go_o,
  output s_dma_desc_t             dma_desc_o,
  input  s_dma_status_t           dma_stats_i,
  input  s_dma_error_t            dma_error_i,
  input  logic                    clear_dma_i,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        q_count_o
);

  localparam int ENTRY_W = $bits(s_dma_desc_t) + ID_W;
  localparam int N_OTH   = (N_REQ > 1) ? N_REQ - 1 : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE,
    ST_CPL
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  s_dma_desc_t         job_desc_q, job_desc_d;
  logic [ID_W-1:0]     job_id_q, job_id_d;
  logic                err_seen_q, err_seen_d;
  s_dma_error_t        cpl_err_q, cpl_err_d;

  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     cand;
  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_push_dat, fifo_pop_dat;
  logic [CNT_W-1:0]    fifo_count;
  s_dma_desc_t         head_desc;
  logic [ID_W-1:0]     head_id;

`ifdef DMA_JOB_SCHED_PRIO_EN
  int                  rr_base;

  // Requester 0 always wins when valid; otherwise rotate over 1..N_REQ-1 from the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    rr_base   = (rr_ptr_q == '0) ? 0 : int'(rr_ptr_q) - 1;
    if (req_valid_i[0]) begin
      grant_vld = 1'b1;
      grant_id  = '0;
    end else if (N_REQ > 1) begin
      for (int off = 0; off < N_REQ - 1; off++) begin
        cand = ID_W'(((rr_base + off) % N_OTH) + 1);
        if (!grant_vld && req_valid_i[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
      end
    end
  end
`else
  // Rotate over all requesters starting at the pointer; first valid one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end
`endif

  assign fifo_push     = grant_vld && !fifo_full;
  assign fifo_push_dat = {req_desc_i[grant_id], grant_id};
  assign {head_desc, head_id} = fifo_pop_dat;

  // One-hot ready to the winner only, and only while there is room in the queue.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_o[i] = fifo_push && (grant_id == ID_W'(i));
    end
  end

  // Pointer moves past the winner on a handshake; strict-priority grants leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fifo_push) begin
`ifdef DMA_JOB_SCHED_PRIO_EN
      if (grant_id != '0) begin
        rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
`else
      rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
`endif
    end
  end

  dma_job_fifo #(
    .W     (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (fifo_push),
    .push_dat (fifo_push_dat),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Job sequencing: pop, drive go until done, wait for dma_fsm to clear, then hold the completion.
  always_comb begin
    state_d     = state_q;
    job_desc_d  = job_desc_q;
    job_id_d    = job_id_q;
    err_seen_d  = err_seen_q;
    cpl_err_d   = cpl_err_q;
    fifo_pop    = 1'b0;
    dma_go_o    = 1'b0;
    dma_desc_o  = '0;
    cpl_valid_o = 1'b0;
    cpl_id_o    = '0;
    cpl_error_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          job_desc_d = head_desc;
          job_id_d   = head_id;
          err_seen_d = 1'b0;
          cpl_err_d  = '0;
          // A zero-length job has nothing for dma_fsm to do: complete it cleanly without go.
          state_d    = (head_desc.num_bytes != '0) ? ST_ISSUE : ST_CPL;
        end
      end
      ST_ISSUE: begin
        dma_go_o   = 1'b1;
        dma_desc_o = job_desc_q;
        if (dma_stats_i.error) begin
          err_seen_d = 1'b1;
        end
        if (dma_stats_i.done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        dma_desc_o = job_desc_q;
        if (dma_stats_i.error) begin
          err_seen_d = 1'b1;
        end
        if (clear_dma_i) begin
          cpl_err_d = err_seen_d ? dma_error_i : '0;
          state_d   = ST_CPL;
        end
      end
      ST_CPL: begin
        dma_desc_o  = job_desc_q;
        cpl_valid_o = 1'b1;
        cpl_id_o    = job_id_q;
        cpl_error_o = cpl_err_q;
        if (cpl_ready_i) begin
          err_seen_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign q_count_o = fifo_count;

  // Scheduler state registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      job_desc_q <= '0;
      job_id_q   <= '0;
      err_seen_q <= 1'b0;
      cpl_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      job_desc_q <= job_desc_d;
      job_id_q   <= job_id_d;
      err_seen_q <= err_seen_d;
      cpl_err_q  <= cpl_err_d;
    end
  end

endmodule
